uart_tx_fifo: RTL and testbench

- Byte FIFO plus issue sequencer that sits directly upstream of the team's UART transmitter.
- Accepts bytes from the host/core side and drains them one at a time into the transmitter's tx_data/tx_req/tx_busy handshake.
- Lets the core queue a burst without polling tx_busy.
- Reports level, full/empty and sticky error flags.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo_mem.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: byte width, TX sequencer states, cfg bit positions
package uart_pkg;

  localparam int UART_DW = 8;

  typedef logic [UART_DW-1:0] uart_byte_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  // cfg register layout, common to this block and the transmitter
  localparam int CFG_EN_BIT     = 0;
  localparam int CFG_PARITY_BIT = 1;
  localparam int CFG_STOP2_BIT  = 2;
  localparam int CFG_BAUD_LSB   = 4;
  localparam int CFG_BAUD_MSB   = 15;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - byte register-array FIFO with pointers, level and sticky overflow
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  uart_byte_t    wr_data_i,
  input  logic          pop_i,
  output uart_byte_t    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o
);

  uart_byte_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          do_wr, do_rd;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // flush wins over both ports; full is judged on the pre-cycle level
  assign do_wr = push_i && !full_o && !flush_i;
  assign do_rd = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      if (push_i && full_o) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - TX byte queue with request/busy issue sequencer toward the UART transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int REQ_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  uart_byte_t    wr_data_i,
  input  logic          wr_en_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          tx_drop_o,
  output uart_byte_t    tx_data_o,
  output logic          tx_req_o,
  input  logic          tx_busy_i
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  uart_byte_t    tx_data_q, tx_data_d;
  logic          tx_req_q, tx_req_d;
  logic          tx_drop_q, tx_drop_d;
  logic          pop;
  uart_byte_t    fifo_rd_data;

  sync_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .push_i     (wr_en_i),
    .wr_data_i  (wr_data_i),
    .pop_i      (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    tx_req_d  = 1'b0;
    tx_drop_d = tx_drop_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_o && !tx_busy_i) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
          tx_req_d  = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // an unanswered request is abandoned so later bytes are not blocked
        if (tx_busy_i) begin
          state_d = S_WAIT_LO;
        end else if (timer_q == TW'(REQ_TIMEOUT - 1)) begin
          tx_drop_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) tx_drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      tx_drop_q <= tx_drop_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_req_o  = tx_req_q;
  assign tx_drop_o = tx_drop_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo with a transmitter busy model
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       full, empty, overflow, tx_drop, tx_req;
  logic [3:0] level;
  logic [7:0] tx_data;
  logic       tx_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  bit hold = 1'b0;
  bit ignore = 1'b0;
  bit check_gap = 1'b0;
  bit model_rst = 1'b0;
  bit pend = 1'b0;
  int busy_len = 160;
  int frame_cnt = 0;
  int fall_cyc = -1;
  int req_cnt = 0;
  int last_req_cyc = -1;
  int prev_req_cyc = -1;

  uart_tx_fifo #(.DEPTH(8), .AW(3), .REQ_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (wr_data),
    .wr_en_i    (wr_en),
    .flush_i    (flush),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow),
    .tx_drop_o  (tx_drop),
    .tx_data_o  (tx_data),
    .tx_req_o   (tx_req),
    .tx_busy_i  (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    wr_data = d;
    wr_en   = 1'b1;
    if (push) exp_q.push_back(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_reqs(input int target, input int limit, input string tag);
    int t = 0;
    while (req_cnt < target && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk(tag, req_cnt, target);
  endtask

  // transmitter model: busy rises the cycle after a request and lasts busy_len cycles
  initial begin
    logic [7:0] e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_rst) begin
        frame_cnt = 0;
        pend = 1'b0;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) fall_cyc = cyc;
      end else if (pend) begin
        pend = 1'b0;
        if (!ignore) frame_cnt = busy_len;
      end
      tx_busy = hold || (frame_cnt > 0);
      if (!model_rst && tx_req === 1'b1) begin
        req_cnt++;
        prev_req_cyc = last_req_cyc;
        last_req_cyc = cyc;
        pend = 1'b1;
        chk("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e);
        end
        if (check_gap && fall_cyc >= 0) chk("b2b_gap", cyc - fall_cyc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, r1;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_txreq", tx_req, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_req_cnt", req_cnt, 0);
    chk("idle_txdata", tx_data, 8'h00);
    chk("idle_overflow", overflow, 0);
    chk("idle_txdrop", tx_drop, 0);

    // single byte, request latency
    busy_len = 160;
    n = cyc;
    wr(8'hA5, 1'b1);
    chk("single_lvl1", level, 1);
    chk("single_noreq_n1", tx_req, 0);
    @(negedge clk);
    chk("single_lvl0", level, 0);
    chk("single_req_n2", tx_req, 1);
    repeat (200) @(negedge clk);
    chk("single_req_cnt", req_cnt, 1);
    chk("single_req_cyc", last_req_cyc, n + 2);
    chk("single_hold_data", tx_data, 8'hA5);
    chk("single_empty", empty, 1);

    // burst to full, overflow, ordered drain
    busy_len = 20;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
    chk("burst_full", full, 1);
    chk("burst_level8", level, 8);
    wr(8'hFF, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level8", level, 8);
    base = req_cnt;
    fall_cyc = -1;
    check_gap = 1'b1;
    hold = 1'b0;
    wait_reqs(base + 8, 1000, "burst_reqs");
    repeat (30) @(negedge clk);
    check_gap = 1'b0;
    chk("burst_req_total", req_cnt, base + 8);
    chk("burst_empty", empty, 1);
    chk("burst_sb_drained", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // flush, including a write in the same cycle
    hold = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h71, 1'b0);
    wr(8'h72, 1'b0);
    wr(8'h73, 1'b0);
    chk("pre_flush_lvl", level, 3);
    flush = 1'b1;
    wr(8'h99, 1'b0);
    flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    base = req_cnt;
    hold = 1'b0;
    repeat (20) @(negedge clk);
    chk("flush_no_req", req_cnt, base);

    // request timeout
    ignore = 1'b1;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h31, 1'b1);
    wr(8'h32, 1'b1);
    base = req_cnt;
    hold = 1'b0;
    wait_reqs(base + 1, 50, "to_req1");
    r1 = last_req_cyc;
    while (cyc < r1 + 4) @(negedge clk);
    chk("to_drop_early", tx_drop, 0);
    @(negedge clk);
    chk("to_drop_set", tx_drop, 1);
    wait_reqs(base + 2, 50, "to_req2");
    chk("to_next_gap", last_req_cyc - prev_req_cyc, 6);
    repeat (10) @(negedge clk);
    chk("to_drop_sticky", tx_drop, 1);
    ignore = 1'b0;

    // async reset while waiting for busy to fall with bytes queued
    busy_len = 50;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) wr(8'h41 + 8'(i), 1'b1);
    base = req_cnt;
    hold = 1'b0;
    wait_reqs(base + 1, 50, "rstw_req");
    repeat (5) @(negedge clk);
    chk("rstw_level3", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_level0", level, 0);
    chk("rstw_txreq", tx_req, 0);
    chk("rstw_txdrop", tx_drop, 0);
    chk("rstw_empty", empty, 1);
    model_rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstw_no_req", req_cnt, base + 1);
    chk("rstw_txdata", tx_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
